// File: rtl/mb_conv_pe_array_if.sv
// Memory-read and output-stream bundle for mb_conv_pe_array.
// Master = conv engine; slave = IFM/weight BRAMs plus the OFM writer.
interface mb_conv_pe_array_if #(
    parameter int unsigned NUM_PE = 16,
    parameter int unsigned ADDR_W = 32
);
    logic                   ifm_rd_en;
    logic [ADDR_W-1:0]      ifm_rd_addr;
    logic [31:0]            ifm_rd_data;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic [32*NUM_PE-1:0]   w_rd_data;
    logic                   ofm_valid;
    logic                   ofm_ready;
    logic [8*NUM_PE-1:0]    ofm_data;
    logic [ADDR_W-1:0]      ofm_addr;

    modport master (
        output ifm_rd_en, ifm_rd_addr, w_rd_addr, ofm_valid, ofm_data, ofm_addr,
        input  ifm_rd_data, w_rd_data, ofm_ready
    );

    modport slave (
        input  ifm_rd_en, ifm_rd_addr, w_rd_addr, ofm_valid, ofm_data, ofm_addr,
        output ifm_rd_data, w_rd_data, ofm_ready
    );
endinterface

// File: rtl/mb_conv_pe_array.sv
// MBConv conv engine: NUM_PE int8 MAC PEs, window address sequencing, requant, activation.
// Optional macro MB_CONV_RELU6_EN selects clamp(r,0,relu_max); otherwise int8 saturation.
module mb_conv_pe_array #(
    parameter int unsigned NUM_PE = 16,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        cfg_kernel_w,
    input  logic [1:0]        cfg_stride,
    input  logic [7:0]        cfg_ifm_w,
    input  logic [9:0]        cfg_ifm_cw,
    input  logic [7:0]        cfg_ofm_w,
    input  logic [6:0]        cfg_groups,
    input  logic [4:0]        cfg_shift,
    input  logic [7:0]        cfg_relu_max,
    input  logic [ADDR_W-1:0] cfg_ifm_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    mb_conv_pe_array_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    localparam int unsigned WORD_W = 8 * LANES;

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_FLUSH, ST_OUT, ST_DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        k_q;
    logic [1:0]        s_q;
    logic [7:0]        iw_q, ow_q;
    logic [9:0]        cwc_q;
    logic [6:0]        grps_q;
    logic [4:0]        shift_q;
    logic [ADDR_W-1:0] ifm_base_q, w_base_q;

    logic [7:0] oy, ox, oy_n, ox_n;
    logic [6:0] grp, grp_n;
    logic [2:0] ky, kx, ky_n, kx_n;
    logic [9:0] cw, cw_n;

    logic [2:0]        k_e;
    logic [1:0]        s_e;
    logic [7:0]        iw_e;
    logic [9:0]        cwc_e;
    logic [ADDR_W-1:0] ifm_base_e, w_base_e;

    logic cfg_ok_c, last_cw_c, last_kx_c, last_ky_c, last_win_c;
    logic first_q, mac_vld, mac_first;

    logic signed [ACC_W-1:0] acc     [NUM_PE];
    logic signed [ACC_W-1:0] acc_nxt [NUM_PE];
    logic [8*NUM_PE-1:0]     ofm_nxt;

    function automatic logic [ADDR_W-1:0] ifm_addr_f(
        input logic [ADDR_W-1:0] base, input logic [1:0] s, input logic [7:0] iw,
        input logic [9:0] cwc, input logic [7:0] y, input logic [7:0] x,
        input logic [2:0] ky_i, input logic [2:0] kx_i, input logic [9:0] c);
        ifm_addr_f = base
            + ((ADDR_W'(y) * ADDR_W'(s) + ADDR_W'(ky_i)) * ADDR_W'(iw)
               + ADDR_W'(x) * ADDR_W'(s) + ADDR_W'(kx_i)) * ADDR_W'(cwc)
            + ADDR_W'(c);
    endfunction

    function automatic logic [ADDR_W-1:0] w_addr_f(
        input logic [ADDR_W-1:0] base, input logic [2:0] k, input logic [9:0] cwc,
        input logic [6:0] g, input logic [2:0] ky_i, input logic [2:0] kx_i,
        input logic [9:0] c);
        w_addr_f = base
            + ADDR_W'(g) * ADDR_W'(k) * ADDR_W'(k) * ADDR_W'(cwc)
            + (ADDR_W'(ky_i) * ADDR_W'(k) + ADDR_W'(kx_i)) * ADDR_W'(cwc)
            + ADDR_W'(c);
    endfunction

    // Addresses for the first word of a layer come straight from the cfg inputs.
    always_comb begin
        k_e        = (state == ST_IDLE) ? cfg_kernel_w : k_q;
        s_e        = (state == ST_IDLE) ? cfg_stride   : s_q;
        iw_e       = (state == ST_IDLE) ? cfg_ifm_w    : iw_q;
        cwc_e      = (state == ST_IDLE) ? cfg_ifm_cw   : cwc_q;
        ifm_base_e = (state == ST_IDLE) ? cfg_ifm_base : ifm_base_q;
        w_base_e   = (state == ST_IDLE) ? cfg_w_base   : w_base_q;
    end

    assign cfg_ok_c = (cfg_kernel_w != 3'd0) && (cfg_stride != 2'd0) && (cfg_stride <= 2'd2)
                   && (cfg_ifm_w != 8'd0) && (cfg_ifm_cw != 10'd0)
                   && (cfg_ofm_w != 8'd0) && (cfg_groups != 7'd0);
    assign last_cw_c  = (cw == cwc_q - 10'd1);
    assign last_kx_c  = (kx == k_q - 3'd1);
    assign last_ky_c  = (ky == k_q - 3'd1);
    assign last_win_c = (grp == grps_q - 7'd1) && (ox == ow_q - 8'd1) && (oy == ow_q - 8'd1);

    // Next state and loop counters; window counters self-clear on the last word.
    always_comb begin
        state_nxt = state;
        oy_n = oy; ox_n = ox; grp_n = grp;
        ky_n = ky; kx_n = kx; cw_n = cw;
        case (state)
            ST_IDLE: begin
                if (start && cfg_ok_c) begin
                    state_nxt = ST_FETCH;
                    oy_n = '0; ox_n = '0; grp_n = '0;
                    ky_n = '0; kx_n = '0; cw_n = '0;
                end
            end
            ST_FETCH: begin
                if (!last_cw_c) begin
                    cw_n = cw + 10'd1;
                end else begin
                    cw_n = '0;
                    if (!last_kx_c) begin
                        kx_n = kx + 3'd1;
                    end else begin
                        kx_n = '0;
                        if (!last_ky_c) begin
                            ky_n = ky + 3'd1;
                        end else begin
                            ky_n      = '0;
                            state_nxt = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: state_nxt = ST_OUT;
            ST_OUT: begin
                if (bus.ofm_ready) begin
                    if (last_win_c) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_FETCH;
                        if (grp != grps_q - 7'd1) begin
                            grp_n = grp + 7'd1;
                        end else begin
                            grp_n = '0;
                            if (ox != ow_q - 8'd1) begin
                                ox_n = ox + 8'd1;
                            end else begin
                                ox_n = '0;
                                oy_n = oy + 8'd1;
                            end
                        end
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            oy <= '0; ox <= '0; grp <= '0; ky <= '0; kx <= '0; cw <= '0;
        end else begin
            state <= state_nxt;
            oy <= oy_n; ox <= ox_n; grp <= grp_n; ky <= ky_n; kx <= kx_n; cw <= cw_n;
        end
    end

    // Layer shape is frozen at launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= '0; s_q <= '0; iw_q <= '0; ow_q <= '0; cwc_q <= '0;
            grps_q <= '0; shift_q <= '0; ifm_base_q <= '0; w_base_q <= '0;
        end else if (state == ST_IDLE && start && cfg_ok_c) begin
            k_q <= cfg_kernel_w; s_q <= cfg_stride; iw_q <= cfg_ifm_w; ow_q <= cfg_ofm_w;
            cwc_q <= cfg_ifm_cw; grps_q <= cfg_groups; shift_q <= cfg_shift;
            ifm_base_q <= cfg_ifm_base; w_base_q <= cfg_w_base;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ifm_rd_en   <= 1'b0;
            bus.ifm_rd_addr <= '0;
            bus.w_rd_addr   <= '0;
            bus.ofm_valid   <= 1'b0;
            bus.ofm_data    <= '0;
            bus.ofm_addr    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
            first_q         <= 1'b0;
            mac_vld         <= 1'b0;
            mac_first       <= 1'b0;
        end else begin
            bus.ifm_rd_en <= (state_nxt == ST_FETCH);
            if (state_nxt == ST_FETCH) begin
                bus.ifm_rd_addr <= ifm_addr_f(ifm_base_e, s_e, iw_e, cwc_e, oy_n, ox_n, ky_n, kx_n, cw_n);
                bus.w_rd_addr   <= w_addr_f(w_base_e, k_e, cwc_e, grp_n, ky_n, kx_n, cw_n);
            end else begin
                bus.ifm_rd_addr <= '0;
                bus.w_rd_addr   <= '0;
            end
            first_q   <= (state_nxt == ST_FETCH) && (ky_n == 3'd0) && (kx_n == 3'd0) && (cw_n == 10'd0);
            mac_vld   <= bus.ifm_rd_en;
            mac_first <= first_q;
            bus.ofm_valid <= (state_nxt == ST_OUT);
            if (state == ST_FLUSH) begin
                bus.ofm_data <= ofm_nxt;
                bus.ofm_addr <= (ADDR_W'(oy) * ADDR_W'(ow_q) + ADDR_W'(ox)) * ADDR_W'(grps_q)
                              + ADDR_W'(grp);
            end
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
            cfg_err <= (state == ST_IDLE) && start && !cfg_ok_c;
        end
    end

    // PE MACs: dot product of LANES int8 pairs, wrapping at ACC_W.
    always_comb begin
        logic signed [7:0]       a, b;
        logic signed [ACC_W-1:0] sum;
        for (int p = 0; p < NUM_PE; p++) begin
            sum = '0;
            for (int l = 0; l < LANES; l++) begin
                a   = bus.ifm_rd_data[8*l +: 8];
                b   = bus.w_rd_data[WORD_W*p + 8*l +: 8];
                sum = sum + ACC_W'(a) * ACC_W'(b);
            end
            acc_nxt[p] = mac_vld ? ((mac_first ? ACC_W'(0) : acc[p]) + sum) : acc[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PE; p++) acc[p] <= acc_nxt[p];
        end
    end

`ifdef MB_CONV_RELU6_EN
    logic [7:0]              rmax_q;
    logic signed [ACC_W-1:0] rmax_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      rmax_q <= '0;
        else if (state == ST_IDLE && start && cfg_ok_c) rmax_q <= cfg_relu_max;
    end

    assign rmax_s = ACC_W'(rmax_q);

    // Requant then ReLU clamp to [0, relu_max].
    always_comb begin
        logic signed [ACC_W-1:0] r;
        ofm_nxt = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            r = acc_nxt[p] >>> shift_q;
            if (r[ACC_W-1])      ofm_nxt[8*p +: 8] = 8'h00;
            else if (r > rmax_s) ofm_nxt[8*p +: 8] = rmax_q;
            else                 ofm_nxt[8*p +: 8] = r[7:0];
        end
    end
`else
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);
    logic unused_relu_max;

    assign unused_relu_max = ^cfg_relu_max;

    // Requant then saturate to int8.
    always_comb begin
        logic signed [ACC_W-1:0] r;
        ofm_nxt = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            r = acc_nxt[p] >>> shift_q;
            if (r > SAT_MAX)      ofm_nxt[8*p +: 8] = 8'h7F;
            else if (r < SAT_MIN) ofm_nxt[8*p +: 8] = 8'h80;
            else                  ofm_nxt[8*p +: 8] = r[7:0];
        end
    end
`endif
endmodule
